// File: rtl/led_panel_pkg.sv
// -----------------------------------------------------------------------------
// led_panel_pkg
// Shared types and constants for the LED panel capture block:
//   - state_t            : scan FSM states (IDLE, SCAN, DONE)
//   - RGB_R/RGB_G/RGB_B  : bit positions of each colour inside a {r,g,b} symbol
//   - DEFAULT_COLS/ROW_W : default panel geometry
//   - CRC_POLY/CRC_INIT  : CRC-16-CCITT constants used by the optional row CRC
//   - crc16_sym          : folds one 3-bit symbol into a CRC, MSB first
// -----------------------------------------------------------------------------
package led_panel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RGB_R = 2;
  localparam int RGB_G = 1;
  localparam int RGB_B = 0;

  localparam int DEFAULT_COLS  = 32;
  localparam int DEFAULT_ROW_W = 6;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic logic [15:0] crc16_sym(input logic [15:0] crc,
                                            input logic [2:0]  sym);
    logic [15:0] c;
    c = crc;
    for (int i = 2; i >= 0; i--) begin
      if (c[15] ^ sym[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/led_panel_edge_det.sv
// -----------------------------------------------------------------------------
// led_panel_edge_det
// Registers one control input and produces a single-cycle edge pulse.
// The pulse compares the live input with its registered copy, so it is
// asserted in the cycle the new level is first sampled.
// Parameters:
//   FALLING : 0 = rising-edge pulse, 1 = falling-edge pulse
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   sig        : input level
//   pulse      : edge pulse
// -----------------------------------------------------------------------------
module led_panel_edge_det #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic pulse
);

  logic sig_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sig_d <= 1'b0;
    else       sig_d <= sig;
  end

  assign pulse = FALLING ? (~sig & sig_d) : (sig & ~sig_d);

endmodule

// File: rtl/led_panel_capture.sv
// -----------------------------------------------------------------------------
// led_panel_capture
// Panel-side receiver for the LED panel serial interface. Rebuilds each row
// as a shift-register panel would, tracks the row address and replays the
// latched row as a pixel stream with per-colour lit counts and sticky
// protocol error flags.
// Optional feature: define LED_PANEL_CAPTURE_CRC_EN to add row_crc, a
// CRC-16-CCITT over the scanned {r,g,b} symbols (column 0 first).
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   sclk_in, latch_in, blank_in  : shift clock, latch strobe, blank (1 = off)
//   aclk_in, arst_in             : row address clock / level reset
//   red_in, green_in, blue_in    : serial colour data
//   clr_err                      : clear sticky error flags
//   pix_valid, pix_col, pix_rgb  : replayed pixel stream
//   row_valid, row_idx           : end-of-scan pulse, row address at scan start
//   red_cnt, green_cnt, blue_cnt : lit pixels per colour in last scanned row
//   err_len, err_overrun         : sticky protocol errors
//   row_crc                      : (CRC build only) CRC of last scanned row
// -----------------------------------------------------------------------------
module led_panel_capture
  import led_panel_pkg::*;
#(
  parameter int COLS  = DEFAULT_COLS,
  parameter int ROW_W = DEFAULT_ROW_W,
  parameter int CNT_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclk_in,
  input  logic                     latch_in,
  input  logic                     blank_in,
  input  logic                     aclk_in,
  input  logic                     arst_in,
  input  logic                     red_in,
  input  logic                     green_in,
  input  logic                     blue_in,
  input  logic                     clr_err,
  output logic                     pix_valid,
  output logic [$clog2(COLS)-1:0]  pix_col,
  output logic [2:0]               pix_rgb,
  output logic                     row_valid,
  output logic [ROW_W-1:0]         row_idx,
  output logic [CNT_W-1:0]         red_cnt,
  output logic [CNT_W-1:0]         green_cnt,
  output logic [CNT_W-1:0]         blue_cnt,
  output logic                     err_len,
`ifdef LED_PANEL_CAPTURE_CRC_EN
  output logic                     err_overrun,
  output logic [15:0]              row_crc
`else
  output logic                     err_overrun
`endif
);

  localparam int                 COL_W        = $clog2(COLS);
  localparam logic [COL_W-1:0]   LAST_COL     = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0]   EXPECT_RISES = CNT_W'(COLS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic                   sclk_rise, latch_rise, blank_fall, aclk_rise;
  logic [2:0]             rgb_d;
  logic [COLS-1:0][2:0]   chain, chain_next, holding;
  logic [CNT_W-1:0]       rise_cnt, rise_next;
  logic [ROW_W-1:0]       row_cnt;
  logic [COL_W-1:0]       col;
  logic                   settle;
  state_t                 state;

  // ---- input stage: registered copies and edge pulses ----
  led_panel_edge_det #(.FALLING(1'b0)) u_sclk  (.clk(clk), .reset(reset), .sig(sclk_in),  .pulse(sclk_rise));
  led_panel_edge_det #(.FALLING(1'b0)) u_latch (.clk(clk), .reset(reset), .sig(latch_in), .pulse(latch_rise));
  led_panel_edge_det #(.FALLING(1'b1)) u_blank (.clk(clk), .reset(reset), .sig(blank_in), .pulse(blank_fall));
  led_panel_edge_det #(.FALLING(1'b0)) u_aclk  (.clk(clk), .reset(reset), .sig(aclk_in),  .pulse(aclk_rise));

  // Shift happens before latch when both edges land together, so the latch
  // and the length check both see the post-shift chain and count.
  always_comb begin
    chain_next = chain;
    rise_next  = rise_cnt;
    if (sclk_rise) begin
      chain_next = {chain[COLS-2:0], rgb_d};
      rise_next  = sat_inc(rise_cnt);
    end
  end

  // ---- shift chain, holding register, row counter, error flags ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_d       <= '0;
      chain       <= '0;
      holding     <= '0;
      rise_cnt    <= '0;
      row_cnt     <= '0;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rgb_d <= {red_in, green_in, blue_in};
      chain <= chain_next;
      if (latch_rise) begin
        holding  <= chain_next;
        rise_cnt <= '0;
      end else begin
        rise_cnt <= rise_next;
      end
      // set wins over clear
      err_len     <= (err_len & ~clr_err) | (latch_rise && (rise_next != EXPECT_RISES));
      err_overrun <= (err_overrun & ~clr_err) | (latch_rise && (state == SCAN));
      if (arst_in)        row_cnt <= '0;
      else if (aclk_rise) row_cnt <= row_cnt + 1'b1;
    end
  end

  // ---- scan FSM: pixel replay and end-of-row pulse ----
  // DONE lasts two cycles so the counts, which trail the pixel registers by
  // one cycle, are final before row_valid rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      settle    <= 1'b0;
      pix_valid <= 1'b0;
      pix_col   <= '0;
      pix_rgb   <= '0;
      row_valid <= 1'b0;
      row_idx   <= '0;
    end else begin
      pix_valid <= 1'b0;
      row_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (blank_fall) begin
            state   <= SCAN;
            col     <= '0;
            row_idx <= row_cnt;
          end
        end
        SCAN: begin
          pix_valid <= 1'b1;
          pix_col   <= col;
          pix_rgb   <= holding[col];
          col       <= col + 1'b1;
          if (col == LAST_COL) begin
            state  <= DONE;
            settle <= 1'b0;
          end
        end
        DONE: begin
          if (settle) begin
            row_valid <= 1'b1;
            settle    <= 1'b0;
            state     <= IDLE;
          end else begin
            settle <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- per-row statistics from the pixel stream ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_cnt   <= '0;
      green_cnt <= '0;
      blue_cnt  <= '0;
`ifdef LED_PANEL_CAPTURE_CRC_EN
      row_crc   <= CRC_INIT;
`endif
    end else if (state == IDLE && blank_fall) begin
      red_cnt   <= '0;
      green_cnt <= '0;
      blue_cnt  <= '0;
`ifdef LED_PANEL_CAPTURE_CRC_EN
      row_crc   <= CRC_INIT;
`endif
    end else if (pix_valid) begin
      red_cnt   <= red_cnt   + CNT_W'(pix_rgb[RGB_R]);
      green_cnt <= green_cnt + CNT_W'(pix_rgb[RGB_G]);
      blue_cnt  <= blue_cnt  + CNT_W'(pix_rgb[RGB_B]);
`ifdef LED_PANEL_CAPTURE_CRC_EN
      row_crc   <= crc16_sym(row_crc, pix_rgb);
`endif
    end
  end

endmodule

// File: tb/tb_led_panel_capture.sv
// -----------------------------------------------------------------------------
// tb_led_panel_capture
// Directed bench for led_panel_capture: loads rows over the serial wires,
// latches, unblanks and compares the replayed stream, counts, row address,
// latency and error flags against hand-derived values. The CRC checks are
// compiled in when LED_PANEL_CAPTURE_CRC_EN is defined.
// -----------------------------------------------------------------------------
module tb_led_panel_capture;

  localparam int COLS  = 32;
  localparam int ROW_W = 6;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             sclk_in, latch_in, blank_in, aclk_in, arst_in;
  logic             red_in, green_in, blue_in, clr_err;
  logic             pix_valid;
  logic [4:0]       pix_col;
  logic [2:0]       pix_rgb;
  logic             row_valid;
  logic [ROW_W-1:0] row_idx;
  logic [CNT_W-1:0] red_cnt, green_cnt, blue_cnt;
  logic             err_len, err_overrun;
`ifdef LED_PANEL_CAPTURE_CRC_EN
  logic [15:0]      row_crc;
  logic [15:0]      crc_zero;
`endif

  led_panel_capture #(.COLS(COLS), .ROW_W(ROW_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .sclk_in(sclk_in), .latch_in(latch_in), .blank_in(blank_in),
    .aclk_in(aclk_in), .arst_in(arst_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .clr_err(clr_err),
    .pix_valid(pix_valid), .pix_col(pix_col), .pix_rgb(pix_rgb),
    .row_valid(row_valid), .row_idx(row_idx),
    .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt),
    .err_len(err_len),
`ifdef LED_PANEL_CAPTURE_CRC_EN
    .err_overrun(err_overrun),
    .row_crc(row_crc)
`else
    .err_overrun(err_overrun)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_row [COLS];
  logic [2:0] got_row [COLS];
  int n_pix, first_c, rv_c, rv_n, col_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_one(input logic [2:0] rgb);
    {red_in, green_in, blue_in} = rgb;
    sclk_in = 1'b0;
    step();
    sclk_in = 1'b1;
    step();
  endtask

  // first shifted symbol ends in the highest column
  task automatic load_row();
    for (int i = COLS - 1; i >= 0; i--) shift_one(exp_row[i]);
  endtask

  task automatic pulse_latch();
    latch_in = 1'b1;
    step();
    latch_in = 1'b0;
    step();
  endtask

  task automatic aclk_pulse();
    aclk_in = 1'b1;
    step();
    aclk_in = 1'b0;
    step();
  endtask

  // Unblank and record the stream for a fixed window; optional latch pulse
  // driven in cycle inject_at of the window.
  task automatic scan_row(input int inject_at);
    n_pix = 0; first_c = -1; rv_c = -1; rv_n = 0; col_err = 0;
    for (int i = 0; i < COLS; i++) got_row[i] = 3'bxxx;
    blank_in = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      step();
      latch_in = (c == inject_at);
      if (pix_valid) begin
        if (first_c < 0) first_c = c;
        if (pix_col != 5'(n_pix)) col_err++;
        got_row[pix_col] = pix_rgb;
        n_pix++;
      end
      if (row_valid) begin
        if (rv_c < 0) rv_c = c;
        rv_n++;
      end
    end
    latch_in = 1'b0;
    blank_in = 1'b1;
    step();
  endtask

  task automatic check_scan(input string t);
    int m;
    m = 0;
    for (int i = 0; i < COLS; i++) if (got_row[i] !== exp_row[i]) m++;
    check({t, "_npix"},    32'(n_pix), 32);
    check({t, "_first"},   32'(first_c), 2);
    check({t, "_rv_lat"},  32'(rv_c - first_c), 33);
    check({t, "_rv_once"}, 32'(rv_n), 1);
    check({t, "_cols"},    32'(col_err), 0);
    check({t, "_data"},    32'(m), 0);
  endtask

`ifdef LED_PANEL_CAPTURE_CRC_EN
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    logic        msb;
    c = 16'hFFFF;
    for (int i = 0; i < COLS; i++)
      for (int b = 2; b >= 0; b--) begin
        msb = c[15];
        c   = c << 1;
        if (msb ^ exp_row[i][b]) c = c ^ 16'h1021;
      end
    return c;
  endfunction
`endif

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    sclk_in = 0; latch_in = 0; blank_in = 1; aclk_in = 0; arst_in = 0;
    red_in = 0; green_in = 0; blue_in = 0; clr_err = 0;
    step(); step();
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_row_valid", 32'(row_valid), 0);
    check("rst_row_idx",   32'(row_idx), 0);
    check("rst_red_cnt",   32'(red_cnt), 0);
    check("rst_err_len",   32'(err_len), 0);
    check("rst_err_ovr",   32'(err_overrun), 0);
`ifdef LED_PANEL_CAPTURE_CRC_EN
    check("rst_crc", 32'(row_crc), 32'h0000FFFF);
`endif
    reset = 1'b0;
    step(); step();

    // even columns green
    for (int i = 0; i < COLS; i++) exp_row[i] = (i % 2 == 0) ? 3'b010 : 3'b000;
    load_row();
    pulse_latch();
    check("t1_err_len", 32'(err_len), 0);
    scan_row(-1);
    check_scan("t1");
    check("t1_green", 32'(green_cnt), 16);
    check("t1_red",   32'(red_cnt), 0);
    check("t1_blue",  32'(blue_cnt), 0);
    check("t1_row_idx", 32'(row_idx), 0);

    // row address: reset then three clocks; then aclk while arst held
    arst_in = 1'b1; step(); arst_in = 1'b0; step();
    repeat (3) aclk_pulse();
    scan_row(-1);
    check("t2_row_idx3", 32'(row_idx), 3);
    arst_in = 1'b1; step();
    aclk_pulse();
    arst_in = 1'b0; step();
    scan_row(-1);
    check("t2_row_idx0", 32'(row_idx), 0);

    // length error, clear, clear colliding with a new error
    for (int i = 0; i < COLS; i++) exp_row[i] = 3'b111;
    for (int i = COLS - 2; i >= 0; i--) shift_one(exp_row[i]);
    pulse_latch();
    check("t3_len_31", 32'(err_len), 1);
    clr_err = 1'b1; step(); clr_err = 1'b0; step();
    check("t3_clr", 32'(err_len), 0);
    for (int i = COLS - 2; i >= 0; i--) shift_one(exp_row[i]);
    latch_in = 1'b1; clr_err = 1'b1; step();
    latch_in = 1'b0; clr_err = 1'b0; step();
    check("t3_set_wins", 32'(err_len), 1);
    clr_err = 1'b1; step(); clr_err = 1'b0; step();

    // last sclk rise coincident with latch: shift counted, data latched
    for (int i = 0; i < COLS; i++) exp_row[i] = 3'(i % 8);
    for (int i = COLS - 1; i >= 1; i--) shift_one(exp_row[i]);
    {red_in, green_in, blue_in} = exp_row[0];
    sclk_in = 1'b0; step();
    sclk_in = 1'b1; latch_in = 1'b1; step();
    sclk_in = 1'b0; latch_in = 1'b0; step(); step();
    check("t3_same_cycle_len", 32'(err_len), 0);
    scan_row(-1);
    check_scan("t3");
    check("t3_red",   32'(red_cnt), 16);
    check("t3_green", 32'(green_cnt), 16);
    check("t3_blue",  32'(blue_cnt), 16);

    // overrun: holding all red, chain all blue, latch mid-scan
    for (int i = 0; i < COLS; i++) exp_row[i] = 3'b100;
    load_row();
    pulse_latch();
    for (int i = 0; i < COLS; i++) exp_row[i] = 3'b001;
    load_row();
    for (int i = 0; i < COLS; i++) exp_row[i] = (i < 10) ? 3'b100 : 3'b001;
    scan_row(10);
    check_scan("t4");
    check("t4_overrun", 32'(err_overrun), 1);
    check("t4_len",     32'(err_len), 0);
    check("t4_red",     32'(red_cnt), 10);
    check("t4_blue",    32'(blue_cnt), 22);

    // reset during a scan
    for (int i = 0; i < COLS; i++) exp_row[i] = 3'b010;
    load_row();
    pulse_latch();
    blank_in = 1'b0;
    repeat (5) step();
    check("t5_pre_valid", 32'(pix_valid), 1);
    reset = 1'b1;
    #1;
    check("t5_rst_valid", 32'(pix_valid), 0);
    check("t5_rst_col",   32'(pix_col), 0);
    check("t5_rst_rgb",   32'(pix_rgb), 0);
    check("t5_rst_green", 32'(green_cnt), 0);
    check("t5_rst_ovr",   32'(err_overrun), 0);
    check("t5_rst_rv",    32'(row_valid), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rv_n = 0; n_pix = 0;
    for (int c = 0; c < 45; c++) begin
      step();
      if (row_valid) rv_n++;
      if (pix_valid) n_pix++;
    end
    check("t5_no_rv",  32'(rv_n), 0);
    check("t5_no_pix", 32'(n_pix), 0);
    blank_in = 1'b1; step(); step();
    for (int i = 0; i < COLS; i++) exp_row[i] = (i < 5) ? 3'b110 : 3'b000;
    load_row();
    pulse_latch();
    scan_row(-1);
    check_scan("t5");
    check("t5_red",   32'(red_cnt), 5);
    check("t5_green", 32'(green_cnt), 5);
    check("t5_blue",  32'(blue_cnt), 0);

`ifdef LED_PANEL_CAPTURE_CRC_EN
    for (int i = 0; i < COLS; i++) exp_row[i] = 3'b000;
    load_row();
    pulse_latch();
    scan_row(-1);
    crc_zero = model_crc();
    check("t6_crc_zero", 32'(row_crc), 32'(crc_zero));
    exp_row[7] = 3'b100;
    load_row();
    pulse_latch();
    scan_row(-1);
    check("t6_crc_flip", 32'(row_crc), 32'(model_crc()));
    check("t6_crc_diff", 32'(row_crc != crc_zero), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_panel_capture.md
Name: led_panel_capture

Overview:
Panel-side receiver for the LED panel serial interface. It sits on the far end of the panel driver's sclk/latch/blank/aclk/arst/RGB wires, all synchronous to the same clk. It rebuilds each row exactly as a shift-register panel would see it, tracks the row address, and replays each displayed row as a pixel stream with per-colour lit counts and protocol error flags. Used as an on-chip loopback monitor and as a verification target for the driver.

Parameters:
COLS, 32, columns per row; shift-chain length and required sclk rises per latch
ROW_W, 6, row address counter width
CNT_W, 6, lit-count width; must satisfy 2^CNT_W > COLS

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sclk_in  in  1  shift clock from driver; panel shifts on rising edge
latch_in  in  1  active-high latch strobe (driver latch_out)
blank_in  in  1  1 = display off
aclk_in  in  1  row address clock; rising edge advances row
arst_in  in  1  row address reset, level-sensitive, active-high
red_in, green_in, blue_in  in  1 each  serial colour data
clr_err  in  1  synchronous clear of sticky error flags
pix_valid  out  1  pixel stream strobe
pix_col  out  $clog2(COLS)  column index of current pixel
pix_rgb  out  3  {r,g,b} of current pixel
row_valid  out  1  one-cycle pulse: row scan complete, counts valid
row_idx  out  ROW_W  row address captured at scan start
red_cnt, green_cnt, blue_cnt  out  CNT_W each  lit pixels per colour in last scanned row
err_len  out  1  sticky: latch seen with rise count != COLS
err_overrun  out  1  sticky: latch edge during SCAN

Behaviour:
- Reset: all outputs 0, shift chain, holding register and row counter 0, rise counter 0, FSM IDLE. Reset mid-scan aborts the scan immediately; no row_valid is produced.
- Input stage: register all inputs once (x_d). Edges: sclk_rise = sclk_in & ~sclk_d; latch_rise, blank_fall and aclk_rise are derived in the same way.
- Shift: on sclk_rise, shift the {r,g,b} sampled in the previous cycle (the value stable before the edge) into column 0. Existing entries move toward column COLS-1. The rise counter increments and saturates at 2^CNT_W-1.
- Latch: on latch_rise, copy the chain to the holding register. err_len is set if rise count != COLS. The rise counter then clears. If sclk_rise and latch_rise occur in the same cycle, shift first, then latch (post-shift data is latched and the rise is counted).
- Row counter: arst_in high forces 0, with priority over aclk_rise. aclk_rise increments, wrapping at 2^ROW_W.
- FSM:
  - IDLE -> SCAN on blank_fall: capture row_idx, clear the colour counts, set col = 0.
  - SCAN: pix_valid = 1, pix_col = col, pix_rgb = holding[col]; accumulate counts; col increments each cycle. After col = COLS-1 -> DONE.
  - DONE: row_valid = 1 for one cycle; counts are final and held until the next SCAN starts; -> IDLE.
- Scan latency: first pixel 2 cycles after blank_in falls (input register + FSM). row_valid comes COLS+1 cycles after the first pixel.
- latch_rise during SCAN: holding is updated anyway and err_overrun is set; the scan continues to completion.
- blank_fall outside IDLE is ignored.
- clr_err clears both flags. If an error event coincides with clr_err, the flag is set (set wins).
- Data driven on sclk falling edges (DDR upper half) is not captured.

Optional Feature:
Macro LED_PANEL_CAPTURE_CRC_EN.
- Defined:
  - Adds output row_crc[15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection), one 3-bit symbol per SCAN cycle, MSB first, column 0 first.
  - row_crc is valid with row_valid and held until the next SCAN starts; reset value 0xFFFF.
- Undefined: the port and logic are absent.

Decomposition:
- Package led_panel_pkg holds:
  - the FSM state enum (IDLE, SCAN, DONE)
  - the RGB bit-order constants
  - the default COLS and ROW_W values
  - the CRC polynomial and init constants
- One sub-module, led_panel_edge_det: register plus rising/falling pulse outputs; instantiated per control input.

Test Plan:
1. Drive 32 sclk rises with pattern column n lit green iff n even, latch, unblank -> 32 pix_valid cycles; green_cnt=16, red_cnt=0, blue_cnt=0; err_len=0; row_valid 33 cycles after first pixel.
2. Three aclk pulses after an arst pulse, then unblank -> row_idx=3. Hold arst_in high through an aclk pulse -> row_idx=0.
3. Latch after 31 rises -> err_len=1. clr_err with no new error -> 0. clr_err in the same cycle as a bad latch -> stays 1.
4. latch_rise 10 cycles into SCAN -> err_overrun=1; scan still emits 32 pixels; the later pixels come from the new holding data.
5. Assert reset 5 cycles into SCAN -> all outputs 0 that cycle; no row_valid; a following clean row scans correctly.
6. CRC_EN build: all-zero row -> row_crc matches a reference model, and differs when a single pixel is flipped to red.
